// File: rtl/stack_path_player_pkg.sv
// Shared definitions for the direction-stack consumer: FSM state encoding and
// the direction codes agreed with the stack's producer.
package stack_path_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_POP   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

endpackage

// File: rtl/stack_path_player.sv
// Drains a fixed-latency direction stack word by word and replays the words on
// a valid/ready stream, finishing with a one-cycle done pulse.
module stack_path_player
    import stack_path_player_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int POP_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             stk_empty,
    input  logic [WIDTH-1:0] stk_data,
    output logic             stk_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] move_count
);

    localparam int                WAIT_W    = $clog2(POP_LAT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(POP_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WIDTH-1:0]  out_dir_reg;
    logic [CNT_W-1:0]  move_count_reg;

    // Abort takes priority over everything, including start in IDLE; the
    // captured word and the move count are deliberately left untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            out_dir_reg    <= '0;
            move_count_reg <= '0;
        end else if (abort) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_CHECK;
                        move_count_reg <= '0;
                    end
                end
                ST_CHECK: begin
                    state_reg <= stk_empty ? ST_DONE : ST_POP;
                end
                ST_POP: begin
                    wait_cnt_reg <= WAIT_LOAD;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Counter reaches zero in the first cycle the popped word is valid.
                    if (wait_cnt_reg == '0) begin
                        out_dir_reg <= stk_data;
                        state_reg   <= ST_EMIT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (move_count_reg != CNT_MAX) begin
                            move_count_reg <= move_count_reg + 1'b1;
                        end
                        state_reg <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign stk_pop    = (state_reg == ST_POP);
    assign out_valid  = (state_reg == ST_EMIT);
    assign done       = (state_reg == ST_DONE);
    assign busy       = (state_reg != ST_IDLE);
    assign out_dir    = out_dir_reg;
    assign move_count = move_count_reg;

endmodule
